// File: rtl/word_aligner_if.sv
// Deserializer-to-decoder receive bus: raw words in, framed symbols and lock status out.
interface word_aligner_if;
    logic [9:0] RxRaw_10;
    logic [9:0] RxParallel_10;
    logic       RxDataK;
    logic       Aligned;
    logic [3:0] CommaOffset;

    modport master (
        output RxRaw_10,
        input  RxParallel_10, RxDataK, Aligned, CommaOffset
    );

    modport slave (
        input  RxRaw_10,
        output RxParallel_10, RxDataK, Aligned, CommaOffset
    );
endinterface

// File: rtl/word_aligner.sv
// K28.5 comma aligner: locks to a repeated comma bit offset and frames 10-bit symbols.
// Optional ALIGNER_BOTH_RD_EN: also recognise the RD+ comma 1100000101.
module word_aligner #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 4
) (
    input  logic          BitCLK_10,
    input  logic          Reset,
    word_aligner_if.slave rx
);

    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam logic [3:0] LOCK_CNT  = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT  = 4'(LOSS_COUNT);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    function automatic logic is_comma(input logic [9:0] sym);
`ifdef ALIGNER_BOTH_RD_EN
        return (sym == K28_5_NEG) || (sym == K28_5_POS);
`else
        return sym == K28_5_NEG;
`endif
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    state_t     state, state_nxt;
    logic [3:0] off, off_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [3:0] err, err_nxt;
    logic [3:0] cnt_inc, err_inc;

    logic [9:0]  hist;
    logic [19:0] win;
    logic [9:0]  cand [10];
    logic [9:0]  hit_vec;
    logic        hit;
    logic [3:0]  k_hit;
    logic [9:0]  sym_nxt;

    assign win = {hist, rx.RxRaw_10};

    // Candidate k starts k bits into the older word.
    for (genvar k = 0; k < 10; k++) begin : g_cand
        assign cand[k]    = win[19-k -: 10];
        assign hit_vec[k] = is_comma(cand[k]);
    end

    assign hit = |hit_vec;

    always_comb begin
        k_hit = 4'd0;
        for (int k = 9; k >= 0; k--) begin
            if (hit_vec[k]) k_hit = 4'(k);
        end
    end

    always_comb begin
        state_nxt = state;
        off_nxt   = off;
        cnt_nxt   = cnt;
        err_nxt   = err;
        cnt_inc   = sat_inc(cnt);
        err_inc   = sat_inc(err);
        case (state)
            UNLOCKED: begin
                if (hit) begin
                    off_nxt   = k_hit;
                    cnt_nxt   = 4'd1;
                    err_nxt   = 4'd0;
                    state_nxt = (LOCK_CNT == 4'd1) ? LOCKED : ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (hit) begin
                    if (k_hit == off) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == LOCK_CNT) begin
                            state_nxt = LOCKED;
                            err_nxt   = 4'd0;
                        end
                    end else begin
                        off_nxt = k_hit;
                        cnt_nxt = 4'd1;
                    end
                end
            end
            LOCKED: begin
                // Offset is frozen while locked; only the loss counter moves.
                if (hit) begin
                    if (k_hit == off) begin
                        err_nxt = 4'd0;
                    end else if (err_inc == LOSS_CNT) begin
                        state_nxt = UNLOCKED;
                        cnt_nxt   = 4'd0;
                        err_nxt   = 4'd0;
                    end else begin
                        err_nxt = err_inc;
                    end
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    // Frame with the next offset so a freshly found comma is the first symbol out.
    always_comb begin
        sym_nxt = '0;
        for (int k = 0; k < 10; k++) begin
            if (off_nxt == 4'(k)) sym_nxt = cand[k];
        end
    end

    always_ff @(posedge BitCLK_10) begin
        if (!Reset) begin
            hist             <= '0;
            state            <= UNLOCKED;
            off              <= '0;
            cnt              <= '0;
            err              <= '0;
            rx.RxParallel_10 <= '0;
            rx.RxDataK       <= 1'b0;
        end else begin
            hist             <= rx.RxRaw_10;
            state            <= state_nxt;
            off              <= off_nxt;
            cnt              <= cnt_nxt;
            err              <= err_nxt;
            rx.RxParallel_10 <= sym_nxt;
            rx.RxDataK       <= is_comma(sym_nxt);
        end
    end

    assign rx.Aligned     = (state == LOCKED);
    assign rx.CommaOffset = off;

endmodule
